// File: rtl/ras_ckpt_if.sv
// ---------------------------------------------------------------------------
// ras_ckpt_if
// Bundles the predict-stage and repair-stage signals of the speculative
// return-address stack so the stack and its user share one connection.
//
// Parameters : ADDR_WIDTH (stored word-address width), DEPTH (entries)
// Signals    :
//   stall          freeze speculative push/pop
//   push_pdc       predicted CALL, with push_addr as return address
//   pop_pdc        predicted RET
//   top_addr       current top entry
//   top_valid      stack not empty
//   ckpt           {count, ptr, top} snapshot before this cycle's update
//   repair_en      EX-stage misprediction repair
//   repair_ckpt    checkpoint carried with the mispredicted instruction
//   repair_kind    real instruction kind (3 = CALL, 4 = RET)
//   repair_ret_pc  real return address for a CALL replay
// Modports   : master drives requests, slave is the stack itself.
// ---------------------------------------------------------------------------
interface ras_ckpt_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 16
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CKPT_W = CNT_W + PTR_W + ADDR_WIDTH;

    logic                  stall;
    logic                  push_pdc;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  pop_pdc;
    logic [ADDR_WIDTH-1:0] top_addr;
    logic                  top_valid;
    logic [CKPT_W-1:0]     ckpt;
    logic                  repair_en;
    logic [CKPT_W-1:0]     repair_ckpt;
    logic [2:0]            repair_kind;
    logic [ADDR_WIDTH-1:0] repair_ret_pc;

    modport master (
        output stall, push_pdc, push_addr, pop_pdc,
        output repair_en, repair_ckpt, repair_kind, repair_ret_pc,
        input  top_addr, top_valid, ckpt
    );

    modport slave (
        input  stall, push_pdc, push_addr, pop_pdc,
        input  repair_en, repair_ckpt, repair_kind, repair_ret_pc,
        output top_addr, top_valid, ckpt
    );
endinterface

// File: rtl/ras_ckpt.sv
// ---------------------------------------------------------------------------
// ras_ckpt
// Speculative return-address stack with single-cycle checkpoint repair.
// Pushed on predicted CALLs, popped on predicted RETs. Every cycle it exposes
// a checkpoint {count, ptr, top}; on an EX misprediction the stack restores
// that checkpoint and replays the real CALL/RET of the offending instruction.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset (stack empty, all entries zero)
//   bus   ras_ckpt_if.slave, see the interface file for the signal list
//
// Optional build macro RAS_STAT_EN adds six 32-bit event counters
// (stat_push, stat_pop, stat_overflow, stat_underflow, stat_repair,
// stat_repair_ret), readable hierarchically; functional behaviour is the same
// with or without it.
// ---------------------------------------------------------------------------
module ras_ckpt #(
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 16
) (
    input  logic       clk,
    input  logic       rstn,
    ras_ckpt_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CKPT_W = CNT_W + PTR_W + ADDR_WIDTH;

    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [2:0]       KIND_CALL = 3'd3;
    localparam logic [2:0]       KIND_RET  = 3'd4;

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      ptr_q,   ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Two write ports: a CALL replay during repair restores mem[p] and
    // writes the real return address into mem[p+1] in the same cycle.
    logic                  wa_en,   wb_en;
    logic [PTR_W-1:0]      wa_idx,  wb_idx;
    logic [ADDR_WIDTH-1:0] wa_data, wb_data;

    logic [CNT_W-1:0]      rep_cnt;
    logic [PTR_W-1:0]      rep_ptr;
    logic [ADDR_WIDTH-1:0] rep_top;

    logic spec_ok, do_push, do_pop;

    assign rep_cnt = bus.repair_ckpt[CKPT_W-1 -: CNT_W];
    assign rep_ptr = bus.repair_ckpt[ADDR_WIDTH +: PTR_W];
    assign rep_top = bus.repair_ckpt[ADDR_WIDTH-1:0];

    // Repair overrides everything; a simultaneous push wins over pop.
    assign spec_ok = !bus.stall && !bus.repair_en;
    assign do_push = spec_ok && bus.push_pdc;
    assign do_pop  = spec_ok && bus.pop_pdc && !bus.push_pdc;

    assign bus.top_addr  = mem_q[ptr_q];
    assign bus.top_valid = (count_q != '0);
    assign bus.ckpt      = {count_q, ptr_q, mem_q[ptr_q]};

    // Next-state selection for pointer, occupancy and the two write ports.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wa_en   = 1'b0;
        wa_idx  = ptr_q;
        wa_data = bus.push_addr;
        wb_en   = 1'b0;
        wb_idx  = ptr_q + PTR_W'(1);
        wb_data = bus.repair_ret_pc;

        if (bus.repair_en) begin
            wa_en   = 1'b1;
            wa_idx  = rep_ptr;
            wa_data = rep_top;
            case (bus.repair_kind)
                KIND_CALL: begin
                    ptr_d   = rep_ptr + PTR_W'(1);
                    wb_en   = 1'b1;
                    wb_idx  = rep_ptr + PTR_W'(1);
                    count_d = (rep_cnt >= FULL) ? FULL : rep_cnt + CNT_W'(1);
                end
                KIND_RET: begin
                    if (rep_cnt != '0) begin
                        ptr_d   = rep_ptr - PTR_W'(1);
                        count_d = rep_cnt - CNT_W'(1);
                    end else begin
                        ptr_d   = rep_ptr;
                        count_d = '0;
                    end
                end
                default: begin
                    ptr_d   = rep_ptr;
                    count_d = rep_cnt;
                end
            endcase
        end else if (do_push) begin
            // Overflow wraps and overwrites the oldest entry; count saturates.
            ptr_d   = ptr_q + PTR_W'(1);
            wa_en   = 1'b1;
            wa_idx  = ptr_q + PTR_W'(1);
            wa_data = bus.push_addr;
            count_d = (count_q >= FULL) ? FULL : count_q + CNT_W'(1);
        end else if (do_pop && (count_q != '0)) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Stack state; entries not addressed by a write port keep their value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wa_en && (wa_idx == PTR_W'(i))) begin
                    mem_q[i] <= wa_data;
                end
                if (wb_en && (wb_idx == PTR_W'(i))) begin
                    mem_q[i] <= wb_data;
                end
            end
        end
    end

`ifdef RAS_STAT_EN
    logic [31:0] stat_push;
    logic [31:0] stat_pop;
    logic [31:0] stat_overflow;
    logic [31:0] stat_underflow;
    logic [31:0] stat_repair;
    logic [31:0] stat_repair_ret;

    // Event counters observed hierarchically; they never affect the stack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_push       <= '0;
            stat_pop        <= '0;
            stat_overflow   <= '0;
            stat_underflow  <= '0;
            stat_repair     <= '0;
            stat_repair_ret <= '0;
        end else begin
            if (do_push) begin
                stat_push <= stat_push + 32'd1;
            end
            if (do_push && (count_q == FULL)) begin
                stat_overflow <= stat_overflow + 32'd1;
            end
            if (do_pop && (count_q != '0)) begin
                stat_pop <= stat_pop + 32'd1;
            end
            if (do_pop && (count_q == '0)) begin
                stat_underflow <= stat_underflow + 32'd1;
            end
            if (bus.repair_en) begin
                stat_repair <= stat_repair + 32'd1;
            end
            if (bus.repair_en && (bus.repair_kind == KIND_RET)) begin
                stat_repair_ret <= stat_repair_ret + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Speculative return-address stack (RAS) for the predict stage, parametrised in depth and address width.
- It is pushed on predicted CALLs and popped on predicted RETs.
- Each prediction emits a compact checkpoint {count, ptr, top}. On an EX-stage misprediction, the stack restores from that checkpoint in one cycle and replays the real action of the offending instruction.
- Successor to the bare stack inside the npc predictor: adds checkpoint repair, occupancy tracking and defined overflow/underflow behaviour.

Parameters:
- ADDR_WIDTH, 30, width of stored return address (word address).
- DEPTH, 16, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), stack pointer width (derived, not overridden).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived).
- CKPT_W, CNT_W+PTR_W+ADDR_WIDTH, checkpoint width (derived).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- stall  in  1  freezes speculative push/pop; repair is not blocked.
- push_pdc  in  1  predicted CALL this cycle.
- push_addr  in  ADDR_WIDTH  return address to push.
- pop_pdc  in  1  predicted RET this cycle.
- top_addr  out  ADDR_WIDTH  mem[ptr], combinational.
- top_valid  out  1  count != 0.
- ckpt  out  CKPT_W  {count, ptr, mem[ptr]} before this cycle's update, combinational.
- repair_en  in  1  EX misprediction repair.
- repair_ckpt  in  CKPT_W  checkpoint carried with the mispredicted instruction.
- repair_kind  in  3  real kind; CALL=3, RET=4, anything else means no replay.
- repair_ret_pc  in  ADDR_WIDTH  real return address when repair_kind is CALL.

Behaviour:
- Reset (async, rstn=0): ptr=0, count=0, all mem entries 0. Outputs are then top_addr=0, top_valid=0, ckpt=0.
- Push/pop act only when stall=0 and repair_en=0. State updates on the next rising edge; top_addr reflects the new state in the same cycle the edge lands, i.e. 1 cycle latency.
- Push: ptr<=ptr+1 (mod DEPTH), mem[ptr+1]<=push_addr, count<=min(count+1, DEPTH).
- Overflow: push at count=DEPTH wraps and silently overwrites the oldest entry; count stays DEPTH.
- Pop with count>0: ptr<=ptr-1 (mod DEPTH), count<=count-1. mem is unchanged.
- Underflow: pop with count=0 is a no-op; top_valid stays 0.
- push_pdc and pop_pdc both high: push only, pop ignored.
- Repair (repair_en=1) overrides push/pop/stall that cycle. Let {c, p, t} = repair_ckpt. Base restore: mem[p]<=t, then one of:
  - kind CALL: ptr<=p+1, mem[p+1]<=repair_ret_pc, count<=min(c+1, DEPTH). This needs two mem writes in one cycle; both must land.
  - kind RET: if c>0 then ptr<=p-1, count<=c-1; else ptr<=p, count<=0.
  - other kind: ptr<=p, count<=c.
- Entries other than p and p+1 are not restored. Deeper corruption from wrong-path pushes beyond DEPTH is accepted.
- Repair while rstn=0: reset wins. Reset deasserting mid-sequence leaves the stack empty, and no pending repair is remembered.
- Pointer arithmetic wraps modulo DEPTH with no extra logic; count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro RAS_STAT_EN.
- Defined: six 32-bit internal counters, all reset to 0 asynchronously:
  - stat_push: each accepted push.
  - stat_pop: each accepted pop with count>0.
  - stat_overflow: push at count=DEPTH.
  - stat_underflow: pop at count=0.
  - stat_repair: each repair_en cycle.
  - stat_repair_ret: repair with kind RET.
  - Counters are read hierarchically by the bench; no port change.
- Undefined: the counters are absent and the functional behaviour is identical.

Test Plan:
- DEPTH=4 throughout.
- Push and pop: reset, push 0x100, 0x200, 0x300 -> top_addr=0x300, count=3. Pop twice -> top_addr=0x100, top_valid=1. Pop -> top_valid=0. Pop again -> no change, stat_underflow=1.
- Overflow: push 0x1..0x5 -> count=4, top_addr=0x5. Pops return 0x5, 0x4, 0x3, 0x2, then top_valid=0, and 0x1 is lost.
- Repair with CALL replay: push 0xA and capture ckpt; wrong-path push 0xB, pop, pop, push 0xC. Repair with the captured ckpt, kind CALL, ret 0xD -> top=0xD; pop -> top=0xA, count=1.
- Repair with RET replay and overwrite recovery: push 0x10, 0x20 and capture ckpt (top 0x20). Pop, push 0x99 (overwrites slot). Repair kind RET -> ptr restored-1, top_addr=0x10, count=1, slot holds 0x20.
- Priority: repair_en, push_pdc and stall asserted together -> only the repair result is visible and the push is dropped. push_pdc and pop_pdc together -> push only.
- Async reset: assert rstn low mid-clock after 3 pushes -> top_valid=0 and top_addr=0 immediately, before the next edge.
